// File: rtl/inp_arbiter_if.sv
// Bundle of the requester-side and input-unit-side signals of the stdin arbiter.
// The arbiter takes the slave view; the surrounding system (requesters plus the
// input unit) takes the master view.
interface inp_arbiter_if #(
  parameter int DW = 16,
  parameter int N  = 4,
  parameter int GW = (N > 1) ? $clog2(N) : 1
);
  logic [N-1:0]  req;
  logic [N-1:0]  ack;
  logic [DW-1:0] data;
  logic [GW-1:0] grant_id;
  logic          busy;
  logic          inp_req;
  logic [DW-1:0] inp_data;
  logic          inp_ack;

  modport slave (
    input  req, inp_data, inp_ack,
    output ack, data, grant_id, busy, inp_req
  );

  modport master (
    output req, inp_data, inp_ack,
    input  ack, data, grant_id, busy, inp_req
  );
endinterface

// File: rtl/inp_arbiter.sv
// Round-robin arbiter sharing one stdin input unit among N 4-phase requesters.
// One transaction at a time: grant, run the downstream req/ack handshake, hand
// the latched value to the granted requester, then wait for its release.
module inp_arbiter #(
  parameter int DW = 16,
  parameter int N  = 4,
  parameter int GW = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst_b,
  inp_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_WAIT_ACK = 2'd1;
  localparam logic [1:0] S_WAIT_REL = 2'd2;
  localparam logic [1:0] S_HOLD     = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [GW-1:0] ptr_q, ptr_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [N-1:0]  ack_q, ack_d;
  logic [DW-1:0] data_q, data_d;
  logic          busy_q, busy_d;
  logic          inp_req_q, inp_req_d;

  logic [GW-1:0] sel;
  logic          found;
  logic [N-1:0]  gnt_oh;
  logic          req_g;
  logic [GW-1:0] nxt_ptr;

  // Granted requester as a one-hot mask, its live request, and the pointer
  // position just past it (so the served requester drops to lowest priority).
  assign gnt_oh  = N'(1) << grant_q;
  assign req_g   = |(bus.req & gnt_oh);
  assign nxt_ptr = GW'((int'(grant_q) + 1) % N);

  // Round-robin search: first set request starting at ptr, wrapping mod N.
  // Walking downward lets the lowest offset overwrite any later match.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (|(bus.req & (N'(1) << ((int'(ptr_q) + k) % N)))) begin
        sel   = GW'((int'(ptr_q) + k) % N);
        found = 1'b1;
      end
    end
  end

  // Transaction FSM: next-state and next-output computation.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    ack_d     = ack_q;
    data_d    = data_q;
    busy_d    = busy_q;
    inp_req_d = inp_req_q;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d   = sel;
          busy_d    = 1'b1;
          inp_req_d = 1'b1;
          state_d   = S_WAIT_ACK;
        end
      end
      S_WAIT_ACK: begin
        // The input unit read always completes, even if the requester withdrew.
        if (bus.inp_ack) begin
          data_d    = bus.inp_data;
          inp_req_d = 1'b0;
          state_d   = S_WAIT_REL;
        end
      end
      S_WAIT_REL: begin
        if (!bus.inp_ack) begin
          if (req_g) begin
            ack_d   = gnt_oh;
            state_d = S_HOLD;
          end else begin
            // Requester gave up: value is dropped, no ack is raised.
            ptr_d   = nxt_ptr;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end
        end
      end
      S_HOLD: begin
        if (!req_g) begin
          ack_d   = '0;
          ptr_d   = nxt_ptr;
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: begin
        ack_d     = '0;
        data_d    = '0;
        grant_d   = '0;
        busy_d    = 1'b0;
        inp_req_d = 1'b0;
        ptr_d     = '0;
        state_d   = S_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared asynchronously by reset.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      grant_q   <= '0;
      ack_q     <= '0;
      data_q    <= '0;
      busy_q    <= 1'b0;
      inp_req_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      ack_q     <= ack_d;
      data_q    <= data_d;
      busy_q    <= busy_d;
      inp_req_q <= inp_req_d;
    end
  end

  assign bus.ack      = ack_q;
  assign bus.data     = data_q;
  assign bus.grant_id = grant_q;
  assign bus.busy     = busy_q;
  assign bus.inp_req  = inp_req_q;

endmodule

// File: doc/inp_arbiter.md
# inp_arbiter

Round-robin arbiter that shares the single stdin `input_unit` among up to `N` requesters, e.g. CU, debug monitor and a second core. It presents one 4-phase `req`/`ack` port per requester and drives the `inp_req`/`inp_ack` handshake of the input unit on their behalf. It latches the read value and returns it to the granted requester only. It sits between the requesters and `input_unit`, in the same clock and reset domain.

## Interface
- `DW`, 16: data width; must match `input_unit`.
- `N`, 4: number of requesters, 1..8.
- `GW`, `$clog2(N)` (minimum 1): width of `grant_id`.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst_b`  in  1  asynchronous active-low reset.
- `req`  in  N  per-requester read request, level, 4-phase.
- `ack`  out  N  per-requester acknowledge, one-hot or zero.
- `data`  out  DW  value returned to requester; shared bus.
- `grant_id`  out  GW  index of the current or last granted requester.
- `busy`  out  1  high from grant until return to IDLE.
- `inp_req`  out  1  request to `input_unit`.
- `inp_data`  in  DW  value from `input_unit`.
- `inp_ack`  in  1  acknowledge from `input_unit`.

## Operation
- All outputs are registered.
- Reset values: `ack`=0, `data`=0, `grant_id`=0, `busy`=0, `inp_req`=0. Internally, round-robin pointer `ptr`=0 and state=IDLE.
- FSM states:
  - **IDLE**
    - If `req` is nonzero, select the first set bit searching `ptr`, `ptr+1`, ... wrapping mod N.
    - Register `grant_id`<=sel, `busy`<=1, `inp_req`<=1, and go to WAIT_ACK.
    - Otherwise stay in IDLE.
  - **WAIT_ACK**
    - Hold `inp_req`=1 until `inp_ack`=1.
    - On `inp_ack`=1: `data`<=`inp_data`, `inp_req`<=0, go to WAIT_REL.
    - There is no timeout; the input unit blocks on stdin.
  - **WAIT_REL**
    - Wait for `inp_ack`=0.
    - If `req[grant_id]`=1: `ack[grant_id]`<=1, go to HOLD.
    - If `req[grant_id]`=0, the requester withdrew. Discard the value without raising `ack`, then `ptr`<=(`grant_id`+1) mod N, `busy`<=0, go to IDLE.
  - **HOLD**
    - Keep `ack[grant_id]`=1 and `data` stable until `req[grant_id]`=0.
    - Then: `ack`<=0, `ptr`<=(`grant_id`+1) mod N, `busy`<=0, go to IDLE.
- Changes on non-granted `req` bits are ignored outside IDLE. Those requests stay pending and are not lost.
- `data` keeps its last value after the transaction and changes only when a new value is latched in WAIT_ACK.
- `grant_id` holds its last value in IDLE.
- Withdrawal of `req[grant_id]` during WAIT_ACK does not abort the downstream handshake. The input unit read always completes.
- The pointer advances past the served requester, so a requester re-asserting immediately loses to any other pending request.
- With N=1 the pointer stays 0 and behaviour is the plain pass-through handshake.
- Reset asserted mid-transaction returns all state to reset values immediately (async). The input unit shares `rst_b`, so both sides restart clean.
- The illegal state encoding recovers to IDLE with all outputs cleared.

## Timing
- With `input_unit` (IDLE→READ→DONE), relative to edge E0, where `req[i]` is sampled high in IDLE:
  - E0: `inp_req`=1 and `busy`=1.
  - E3: `inp_ack`=1.
  - E4: `data` latched and `inp_req`=0.
  - E5: `inp_ack`=0.
  - E6: `ack[i]`=1.
- Minimum latency: `req` seen to `ack` = 6 edges.
- Release: `req[i]` sampled low at edge Ek → `ack`=0 and `busy`=0 at Ek. The earliest next grant is at Ek+1.
- Back-to-back minimum: one IDLE cycle between transactions.
- `data` is valid no later than the cycle `ack` rises and is stable while `ack`=1.
- `inp_req` never rises while `inp_ack`=1. It never falls before `inp_ack`=1, except on reset.

## Test plan
- Single request: `req`=0001, `inp_data`=16'd1234.
  - Required: `inp_req` pulses once, `ack`=0001 at E6, `data`=1234.
  - After `req` drops: `ack`=0 and `busy`=0 next edge.
- Simultaneous `req`=1111 held, stdin values 10, 20, 30, 40, each requester dropping `req` after its ack.
  - Required: grants in order 0,1,2,3, each receiving its value.
  - `ack` is never multi-hot.
- Fairness: requester 0 re-asserts immediately after release while `req[2]`=1 is pending.
  - Required: requester 2 is served before requester 0 again; `ptr` is 1 after serving 0.
- Withdrawal: `req[1]` dropped during WAIT_ACK.
  - Required: downstream handshake completes, `ack[1]` never rises, `busy` clears, next pending requester granted.
- Long hold: requester keeps `req`=1 for 50 cycles after `ack` with `req[3]` pending.
  - Required: `ack` and `data` stable, no new `inp_req`.
  - Requester 3 is granted only after the release.
- Reset mid-WAIT_ACK: `rst_b`=0 asynchronously.
  - Required: all outputs 0 immediately.
  - After release, a fresh `req`=0100 is served normally starting from `ptr`=0.
